// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined Y-86 execute ALU: operation and
// condition encodings, condition-code reset value and condition evaluator.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_op_e;

    typedef enum logic [2:0] {
        COND_ALWAYS = 3'd0,
        COND_LE     = 3'd1,
        COND_L      = 3'd2,
        COND_E      = 3'd3,
        COND_NE     = 3'd4,
        COND_GE     = 3'd5,
        COND_G      = 3'd6,
        COND_RSVD   = 3'd7
    } cond_e;

    // Condition codes are packed {ZF,SF,OF}; reset leaves "equal" set.
    localparam logic [2:0] CC_RESET = 3'b100;

    // Y-86 jump/cmov predicate evaluated against a {ZF,SF,OF} vector.
    function automatic logic cond_eval(input logic [2:0] cc, input logic [2:0] fn);
        logic zf;
        logic sf;
        logic of;
        logic lt;
        zf = cc[2];
        sf = cc[1];
        of = cc[0];
        lt = sf ^ of;
        case (fn)
            COND_ALWAYS: cond_eval = 1'b1;
            COND_LE:     cond_eval = lt | zf;
            COND_L:      cond_eval = lt;
            COND_E:      cond_eval = zf;
            COND_NE:     cond_eval = !zf;
            COND_GE:     cond_eval = !lt;
            COND_G:      cond_eval = !lt && !zf;
            default:     cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Valid/ready operation and result channels of the pipelined ALU.
// master: producer/consumer side; slave: the ALU itself.
interface alu_pipe_if #(
    parameter int WIDTH = 64
) ();
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_set_cc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zf;
    logic             out_sf;
    logic             out_of;

    modport master (
        output in_valid, in_op, in_a, in_b, in_set_cc, out_ready,
        input  in_ready, out_valid, out_result, out_zf, out_sf, out_of
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_set_cc, out_ready,
        output in_ready, out_valid, out_result, out_zf, out_sf, out_of
    );
endinterface

// File: rtl/alu_core.sv
// Combinational WIDTH-bit two's-complement datapath: ADD/SUB/AND/XOR with
// zero, sign and signed-overflow flags. Carry-out is discarded.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [1:0]              op_i,
    input  logic signed [WIDTH-1:0] a_i,
    input  logic signed [WIDTH-1:0] b_i,
    output logic signed [WIDTH-1:0] result_o,
    output logic                    zf_o,
    output logic                    sf_o,
    output logic                    of_o
);

    logic sa;
    logic sb;
    logic sr;

    assign sa = a_i[WIDTH-1];
    assign sb = b_i[WIDTH-1];
    assign sr = result_o[WIDTH-1];

    // Select the operation result and its overflow rule.
    always_comb begin
        result_o = '0;
        of_o     = 1'b0;
        case (op_i)
            ALU_ADD: begin
                result_o = a_i + b_i;
                of_o     = (sa == sb) && (sr != sa);
            end
            ALU_SUB: begin
                result_o = a_i - b_i;
                of_o     = (sa != sb) && (sr != sa);
            end
            ALU_AND: result_o = a_i & b_i;
            default: result_o = a_i ^ b_i;
        endcase
    end

    assign zf_o = (result_o == '0);
    assign sf_o = sr;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready Y-86 execute ALU with architectural {ZF,SF,OF}.
// Optional feature macro: ALU_COND_EN -- when defined, cnd evaluates the
// Y-86 condition selected by cond_fn against cc; otherwise cnd is 1.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic         clk,
    input  logic         rst,
    alu_pipe_if.slave    bus,
    input  logic [2:0]   cond_fn,
    output logic [2:0]   cc,
    output logic         cnd
);

    // Stage 1: registered operation
    logic             vld_p1_q, vld_p1_d;
    logic [1:0]       op_p1_q;
    logic [WIDTH-1:0] a_p1_q;
    logic [WIDTH-1:0] b_p1_q;
    logic             set_cc_p1_q;

    // Stage 2: registered result and flags
    logic             vld_p2_q, vld_p2_d;
    logic [WIDTH-1:0] result_p2_q;
    logic             zf_p2_q, sf_p2_q, of_p2_q;

    logic [2:0]       cc_q, cc_d;

    logic signed [WIDTH-1:0] result_c;
    logic             zf_c, sf_c, of_c;
    logic             accept;
    logic             s2_load;

    // Stage 2 takes a new op whenever it is empty or being drained this cycle.
    assign s2_load       = vld_p1_q && (!vld_p2_q || bus.out_ready);
    assign bus.in_ready  = !vld_p1_q || s2_load;
    assign accept        = bus.in_valid && bus.in_ready;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op_i     (op_p1_q),
        .a_i      (a_p1_q),
        .b_i      (b_p1_q),
        .result_o (result_c),
        .zf_o     (zf_c),
        .sf_o     (sf_c),
        .of_o     (of_c)
    );

    // Next-state for stage valids and the condition-code register.
    always_comb begin
        vld_p1_d = vld_p1_q;
        vld_p2_d = vld_p2_q;
        cc_d     = cc_q;
        if (accept) begin
            vld_p1_d = 1'b1;
        end else if (s2_load) begin
            vld_p1_d = 1'b0;
        end
        if (s2_load) begin
            vld_p2_d = 1'b1;
        end else if (bus.out_ready) begin
            vld_p2_d = 1'b0;
        end
        if (s2_load && set_cc_p1_q) begin
            cc_d = {zf_c, sf_c, of_c};
        end
    end

    // Control state: stage valids and cc, flushed by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            cc_q     <= CC_RESET;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            cc_q     <= cc_d;
        end
    end

    // Stage 1 operand capture; contents are meaningless while vld_p1_q is low.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p1_q     <= bus.in_op;
            a_p1_q      <= bus.in_a;
            b_p1_q      <= bus.in_b;
            set_cc_p1_q <= bus.in_set_cc;
        end
    end

    // Stage 2 result capture; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_p2_q <= '0;
            zf_p2_q     <= 1'b0;
            sf_p2_q     <= 1'b0;
            of_p2_q     <= 1'b0;
        end else if (s2_load) begin
            result_p2_q <= result_c;
            zf_p2_q     <= zf_c;
            sf_p2_q     <= sf_c;
            of_p2_q     <= of_c;
        end
    end

    assign bus.out_valid  = vld_p2_q;
    assign bus.out_result = result_p2_q;
    assign bus.out_zf     = zf_p2_q;
    assign bus.out_sf     = sf_p2_q;
    assign bus.out_of     = of_p2_q;
    assign cc             = cc_q;

`ifdef ALU_COND_EN
    assign cnd = cond_eval(cc_q, cond_fn);
`else
    logic unused_cond_fn;
    assign unused_cond_fn = ^cond_fn;
    assign cnd = 1'b1;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed vectors push hand-computed results
// into a queue, monitors pop and compare on each out_valid&&out_ready.
module tb_alu_pipe;
    import alu_pkg::*;

`ifdef ALU_COND_EN
    localparam bit COND_EN = 1'b1;
`else
    localparam bit COND_EN = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] r;
        logic        z;
        logic        s;
        logic        o;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [2:0] cond_fn;
    logic [2:0] cc, cc8;
    logic cnd, cnd8;
    int checks = 0;
    int errors = 0;
    exp_t q[$];
    exp_t q8[$];
    logic [63:0] held;

    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(64)) ifc ();
    alu_pipe_if #(.WIDTH(8))  ifc8 ();

    alu_pipe #(.WIDTH(64)) dut (
        .clk(clk), .rst(rst), .bus(ifc), .cond_fn(cond_fn), .cc(cc), .cnd(cnd)
    );
    alu_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .bus(ifc8), .cond_fn(cond_fn), .cc(cc8), .cnd(cnd8)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send64(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic sc, input logic push, input logic [63:0] r,
                          input logic z, input logic s, input logic o);
        int n = 0;
        ifc.in_valid = 1'b1; ifc.in_op = op; ifc.in_a = a; ifc.in_b = b; ifc.in_set_cc = sc;
        #1;
        while (!ifc.in_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL send64_timeout: in_ready stuck at %b, required 1", ifc.in_ready);
        end else if (push) begin
            q.push_back('{r: r, z: z, s: s, o: o});
        end
        @(negedge clk);
    endtask

    task automatic send8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic sc, input logic [7:0] r,
                         input logic z, input logic s, input logic o);
        int n = 0;
        ifc8.in_valid = 1'b1; ifc8.in_op = op; ifc8.in_a = a; ifc8.in_b = b; ifc8.in_set_cc = sc;
        #1;
        while (!ifc8.in_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL send8_timeout: in_ready stuck at %b, required 1", ifc8.in_ready);
        end else begin
            q8.push_back('{r: {56'd0, r}, z: z, s: s, o: o});
        end
        @(negedge clk);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((q.size() != 0 || q8.size() != 0) && n < 100) begin
            @(negedge clk); n++;
        end
        chk(nm, 64'(q.size() + q8.size()), 64'd0);
    endtask

    // Monitor for the 64-bit instance
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (!rst && ifc.out_valid && ifc.out_ready) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out64_unexpected: got %h, required no output", ifc.out_result);
                end else begin
                    e = q.pop_front();
                    chk("res64", ifc.out_result, e.r);
                    chk("flags64", {61'd0, ifc.out_zf, ifc.out_sf, ifc.out_of}, {61'd0, e.z, e.s, e.o});
                end
            end
        end
    end

    // Monitor for the 8-bit instance
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (!rst && ifc8.out_valid && ifc8.out_ready) begin
                if (q8.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out8_unexpected: got %h, required no output", ifc8.out_result);
                end else begin
                    e = q8.pop_front();
                    chk("res8", {56'd0, ifc8.out_result}, e.r);
                    chk("flags8", {61'd0, ifc8.out_zf, ifc8.out_sf, ifc8.out_of}, {61'd0, e.z, e.s, e.o});
                end
            end
        end
    end

    initial begin
        logic [63:0] bp_exp [8];
        bp_exp = '{64'h11, 64'h12, 64'h13, 64'h14, 64'h15, 64'h16, 64'h17, 64'h18};

        rst = 1'b1; cond_fn = COND_ALWAYS;
        ifc.in_valid = 1'b0; ifc.in_op = 2'd0; ifc.in_a = '0; ifc.in_b = '0;
        ifc.in_set_cc = 1'b0; ifc.out_ready = 1'b1;
        ifc8.in_valid = 1'b0; ifc8.in_op = 2'd0; ifc8.in_a = '0; ifc8.in_b = '0;
        ifc8.in_set_cc = 1'b0; ifc8.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        chk("rst_in_ready", {63'd0, ifc.in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, ifc.out_valid}, 64'd0);
        chk("rst_out_result", ifc.out_result, 64'd0);
        chk("rst_flags", {61'd0, ifc.out_zf, ifc.out_sf, ifc.out_of}, 64'd0);
        chk("rst_cc", {61'd0, cc}, 64'd4);
        chk("rst_cnd_always", {63'd0, cnd}, 64'd1);
        @(negedge clk);

        // Latency: out_valid rises after the edge following acceptance.
        send64(ALU_SUB, 64'd5, 64'd1, 1'b0, 1'b1, 64'd4, 1'b0, 1'b0, 1'b0);
        ifc.in_valid = 1'b0;
        #2 chk("lat_after_accept", {63'd0, ifc.out_valid}, 64'd0);
        @(negedge clk);
        #2 chk("lat_next_cycle", {63'd0, ifc.out_valid}, 64'd1);
        @(negedge clk);

        // Arithmetic vectors, back to back
        send64(ALU_SUB, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1'b1,
               64'd4, 1'b0, 1'b0, 1'b0);
        send64(ALU_SUB, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 1'b1,
               64'h8000_0000_0000_0004, 1'b0, 1'b1, 1'b1);
        send64(ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1,
               64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1);
        send64(ALU_XOR, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1,
               64'd0, 1'b1, 1'b0, 1'b0);
        ifc.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 chk("cc_after_sub_of", {61'd0, cc}, 64'd3);
        cond_fn = COND_L;
        #1 chk("cnd_l", {63'd0, cnd}, COND_EN ? 64'd0 : 64'd1);
        cond_fn = COND_GE;
        #1 chk("cnd_ge", {63'd0, cnd}, 64'd1);
        @(negedge clk);

        send64(ALU_AND, 64'hF0, 64'h0F, 1'b1, 1'b1, 64'd0, 1'b1, 1'b0, 1'b0);
        ifc.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 chk("cc_after_and", {61'd0, cc}, 64'd4);
        cond_fn = COND_E;
        #1 chk("cnd_e", {63'd0, cnd}, 64'd1);
        cond_fn = COND_NE;
        #1 chk("cnd_ne", {63'd0, cnd}, COND_EN ? 64'd0 : 64'd1);
        cond_fn = COND_RSVD;
        #1 chk("cnd_rsvd", {63'd0, cnd}, COND_EN ? 64'd0 : 64'd1);
        cond_fn = COND_ALWAYS;
        @(negedge clk);

        // Backpressure: 8 ops, consumer stalled for 4 cycles
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send64(ALU_ADD, 64'(i + 1), 64'h10, 1'b0, 1'b1, bp_exp[i], 1'b0, 1'b0, 1'b0);
                end
                ifc.in_valid = 1'b0;
            end
            begin
                ifc.out_ready = 1'b0;
                repeat (2) @(negedge clk);
                #2;
                chk("bp_in_ready_low", {63'd0, ifc.in_ready}, 64'd0);
                chk("bp_out_valid", {63'd0, ifc.out_valid}, 64'd1);
                held = ifc.out_result;
                @(negedge clk);
                #2;
                chk("bp_hold_stable", ifc.out_result, held);
                chk("bp_head_value", ifc.out_result, 64'h11);
                @(negedge clk);
                ifc.out_ready = 1'b1;
            end
        join
        drain("bp_all_drained");
        @(negedge clk);

        // Reset with both stages full: ops are discarded, cc restored
        ifc.out_ready = 1'b0;
        send64(ALU_SUB, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 1'b0,
               64'd0, 1'b0, 1'b0, 1'b0);
        send64(ALU_ADD, 64'd1, 64'd2, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        ifc.in_valid = 1'b0;
        #2;
        chk("full_cc_loaded", {61'd0, cc}, 64'd3);
        chk("full_out_valid", {63'd0, ifc.out_valid}, 64'd1);
        chk("full_in_ready", {63'd0, ifc.in_ready}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("flush_out_valid", {63'd0, ifc.out_valid}, 64'd0);
        chk("flush_in_ready", {63'd0, ifc.in_ready}, 64'd1);
        chk("flush_cc", {61'd0, cc}, 64'd4);
        chk("flush_result", ifc.out_result, 64'd0);
        ifc.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2 chk("flush_no_ghost", {63'd0, ifc.out_valid}, 64'd0);
        @(negedge clk);

        // WIDTH=8 overflow cases
        send8(ALU_SUB, 8'h7F, 8'hFB, 1'b1, 8'h84, 1'b0, 1'b1, 1'b1);
        send8(ALU_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
        send8(ALU_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
        send8(ALU_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        ifc8.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 chk("cc8_after_sub_of", {61'd0, cc8}, 64'd3);
        cond_fn = COND_L;
        #1 chk("cnd8_l", {63'd0, cnd8}, COND_EN ? 64'd0 : 64'd1);
        cond_fn = COND_ALWAYS;
        drain("w8_all_drained");
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
